// File: rtl/vdu_scan_gen.sv
// Text-mode video scan generator: raster timing, cell/pixel counters,
// scrolled VRAM addressing and blinking cursor, all registered and aligned.
module vdu_scan_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0,
    parameter int CELL_W   = 8,
    parameter int CELL_H   = 20,
    parameter int ROWS     = 24,
    parameter int BLINK_FR = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_repeat,
    input  logic        i_scroll_valid,
    input  logic [4:0]  i_scroll,
    input  logic        i_cursor_en,
    input  logic [4:0]  i_cursor_row,
    input  logic [6:0]  i_cursor_col,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_visible,
    output logic        o_frame_start,
    output logic        o_line_start,
    output logic [6:0]  o_cell_col,
    output logic [4:0]  o_cell_row,
    output logic [2:0]  o_px,
    output logic [4:0]  o_py,
    output logic [10:0] o_vram_addr,
    output logic        o_cursor_hit,
    output logic        o_blink
);

    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_VIS + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_VIS + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;
    localparam int C1     = H_VIS / CELL_W;
    localparam int C2     = H_VIS / (CELL_W * 2);
    localparam int C4     = H_VIS / (CELL_W * 4);

    logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [1:0]  rsel_q, rsel_nxt, rep_q, rep_nxt, b_rep, rep_last;
    logic [2:0]  px_q, px_nxt, b_px;
    logic [6:0]  col_q, col_nxt, b_col, col_last;
    logic [4:0]  py_q, py_nxt, b_py;
    logic [4:0]  row_q, row_nxt, b_row, scroll_q;
    logic [7:0]  fcnt_q, fcnt_nxt;
    logic        blink_nxt, fs_nxt, ls_nxt, vis_nxt;
    logic        hs_on, vs_on, line_end, hit_nxt;
    logic [11:0] vrow, addr_nxt, scroll_mod;
    logic        unused_bits;

    // Every output register is loaded with the description of the pixel
    // the raster counters move to on this edge.
    always_comb begin
        h_nxt = h_cnt + 12'd1;
        v_nxt = v_cnt;
        if (h_cnt == 12'(H_TOT - 1)) begin
            h_nxt = '0;
            v_nxt = (v_cnt == 12'(V_TOT - 1)) ? '0 : v_cnt + 12'd1;
        end
    end

    assign fs_nxt   = (h_nxt == '0) && (v_nxt == '0);
    assign ls_nxt   = (h_nxt == '0) && (v_nxt < 12'(V_VIS));
    assign vis_nxt  = (h_nxt < 12'(H_VIS)) && (v_nxt < 12'(V_VIS));
    assign hs_on    = (h_nxt >= 12'(HS_BEG)) && (h_nxt < 12'(HS_END));
    assign vs_on    = (v_nxt >= 12'(VS_BEG)) && (v_nxt < 12'(VS_END));
    assign line_end = (h_cnt == 12'(H_VIS - 1)) && (v_cnt < 12'(V_VIS));
    assign rsel_nxt = fs_nxt ? i_repeat : rsel_q;

    always_comb begin
        rep_last = 2'd0;
        col_last = 7'(C1 - 1);
        unique case (1'b1)
            rsel_nxt == 2'd1: begin
                rep_last = 2'd1;
                col_last = 7'(C2 - 1);
            end
            rsel_nxt == 2'd2: begin
                rep_last = 2'd3;
                col_last = 7'(C4 - 1);
            end
            default: begin
                rep_last = 2'd0;
                col_last = 7'(C1 - 1);
            end
        endcase
    end

    // Counters hold the position of the next visible pixel to be shown.
    always_comb begin
        b_rep   = fs_nxt ? '0 : rep_q;
        b_px    = fs_nxt ? '0 : px_q;
        b_col   = fs_nxt ? '0 : col_q;
        b_py    = fs_nxt ? '0 : py_q;
        b_row   = fs_nxt ? '0 : row_q;
        rep_nxt = b_rep;
        px_nxt  = b_px;
        col_nxt = b_col;
        py_nxt  = b_py;
        row_nxt = b_row;
        if (vis_nxt) begin
            if (b_rep == rep_last) begin
                rep_nxt = '0;
                if (b_px == 3'(CELL_W - 1)) begin
                    px_nxt  = '0;
                    col_nxt = (b_col == col_last) ? '0 : b_col + 7'd1;
                end else begin
                    px_nxt = b_px + 3'd1;
                end
            end else begin
                rep_nxt = b_rep + 2'd1;
            end
        end
        if (line_end) begin
            if (b_py == 5'(CELL_H - 1)) begin
                py_nxt  = '0;
                row_nxt = (b_row == 5'(ROWS - 1)) ? '0 : b_row + 5'd1;
            end else begin
                py_nxt = b_py + 5'd1;
            end
        end
    end

    always_comb begin
        fcnt_nxt  = fcnt_q;
        blink_nxt = o_blink;
        if (fs_nxt) begin
            if (fcnt_q == 8'(BLINK_FR - 1)) begin
                fcnt_nxt  = '0;
                blink_nxt = ~o_blink;
            end else begin
                fcnt_nxt = fcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        vrow = 12'(b_row) + 12'(scroll_q);
        if (vrow >= 12'(ROWS)) vrow = vrow - 12'(ROWS);
        addr_nxt   = vrow * 12'd80 + 12'(b_col);
        scroll_mod = 12'(i_scroll) % 12'(ROWS);
    end

    assign hit_nxt = vis_nxt && i_cursor_en && blink_nxt &&
                     (b_row == i_cursor_row) && (b_col == i_cursor_col);
    assign unused_bits = ^{addr_nxt[11], scroll_mod[11:5]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= 12'(V_VIS);
            rsel_q   <= '0;
            rep_q    <= '0;
            px_q     <= '0;
            col_q    <= '0;
            py_q     <= '0;
            row_q    <= '0;
            scroll_q <= '0;
            fcnt_q   <= '0;
        end else begin
            h_cnt  <= h_nxt;
            v_cnt  <= v_nxt;
            rsel_q <= rsel_nxt;
            rep_q  <= rep_nxt;
            px_q   <= px_nxt;
            col_q  <= col_nxt;
            py_q   <= py_nxt;
            row_q  <= row_nxt;
            fcnt_q <= fcnt_nxt;
            if (i_scroll_valid) scroll_q <= scroll_mod[4:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_visible     <= 1'b0;
            o_frame_start <= 1'b0;
            o_line_start  <= 1'b0;
            o_cell_col    <= '0;
            o_cell_row    <= '0;
            o_px          <= '0;
            o_py          <= '0;
            o_vram_addr   <= '0;
            o_cursor_hit  <= 1'b0;
            o_blink       <= 1'b0;
        end else begin
            o_hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            o_visible     <= vis_nxt;
            o_frame_start <= fs_nxt;
            o_line_start  <= ls_nxt;
            o_cursor_hit  <= hit_nxt;
            o_blink       <= blink_nxt;
            if (vis_nxt) begin
                o_cell_col  <= b_col;
                o_cell_row  <= b_row;
                o_px        <= b_px;
                o_py        <= b_py;
                o_vram_addr <= addr_nxt[10:0];
            end
        end
    end

endmodule

// File: tb/tb_vdu_scan_gen.sv
// Bench for vdu_scan_gen: per-pixel scoreboard against a raster model
// plus directed timing, repeat, scroll, blink and reset checks.
module tb_vdu_scan_gen;

    localparam int H_VIS    = 32;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 6;
    localparam int V_VIS    = 8;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam bit SYNC_POL = 1'b0;
    localparam int CELL_W   = 4;
    localparam int CELL_H   = 2;
    localparam int ROWS     = 4;
    localparam int BLINK_FR = 2;
    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOT * V_TOT;
    localparam logic [37:0] RST_VEC = {~SYNC_POL, ~SYNC_POL, 36'd0};

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [1:0]  i_repeat = 2'd0;
    logic        i_scroll_valid = 1'b0;
    logic [4:0]  i_scroll = 5'd0;
    logic        i_cursor_en = 1'b1;
    logic [4:0]  i_cursor_row = 5'd2;
    logic [6:0]  i_cursor_col = 7'd3;
    logic        o_hsync, o_vsync, o_visible, o_frame_start, o_line_start;
    logic [6:0]  o_cell_col;
    logic [4:0]  o_cell_row;
    logic [2:0]  o_px;
    logic [4:0]  o_py;
    logic [10:0] o_vram_addr;
    logic        o_cursor_hit, o_blink;
    logic [37:0] dut_vec;

    int n_chk = 0;
    int n_err = 0;
    int nfs   = 0;

    logic [37:0] sbq[$];
    int m_h = 0, m_v = V_VIS, m_r = 1, m_scroll = 0, m_fc = 0;
    int m_col = 0, m_row = 0, m_px = 0, m_py = 0, m_addr = 0;
    bit m_blink = 1'b0;

    vdu_scan_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .ROWS(ROWS), .BLINK_FR(BLINK_FR)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_repeat(i_repeat),
        .i_scroll_valid(i_scroll_valid), .i_scroll(i_scroll),
        .i_cursor_en(i_cursor_en), .i_cursor_row(i_cursor_row),
        .i_cursor_col(i_cursor_col), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_visible(o_visible), .o_frame_start(o_frame_start),
        .o_line_start(o_line_start), .o_cell_col(o_cell_col),
        .o_cell_row(o_cell_row), .o_px(o_px), .o_py(o_py),
        .o_vram_addr(o_vram_addr), .o_cursor_hit(o_cursor_hit),
        .o_blink(o_blink)
    );

    assign dut_vec = {o_hsync, o_vsync, o_visible, o_frame_start,
                      o_line_start, o_cell_col, o_cell_row, o_px, o_py,
                      o_vram_addr, o_cursor_hit, o_blink};

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [37:0] got,
                         input logic [37:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = V_VIS; m_r = 1; m_scroll = 0; m_fc = 0;
        m_blink = 1'b0;
        m_col = 0; m_row = 0; m_px = 0; m_py = 0; m_addr = 0;
        sbq.delete();
    endtask

    // Cell position is derived directly from raster coordinates.
    task automatic model_step();
        logic hs, vs, vis, fs, ls, hit;
        m_h++;
        if (m_h == H_TOT) begin
            m_h = 0;
            m_v++;
            if (m_v == V_TOT) m_v = 0;
        end
        fs = (m_h == 0) && (m_v == 0);
        if (fs) begin
            case (i_repeat)
                2'd1: m_r = 2;
                2'd2: m_r = 4;
                default: m_r = 1;
            endcase
            if (m_fc == BLINK_FR - 1) begin
                m_fc = 0;
                m_blink = ~m_blink;
            end else begin
                m_fc++;
            end
        end
        vis = (m_h < H_VIS) && (m_v < V_VIS);
        if (vis) begin
            m_col  = m_h / (CELL_W * m_r);
            m_px   = (m_h / m_r) % CELL_W;
            m_py   = m_v % CELL_H;
            m_row  = (m_v / CELL_H) % ROWS;
            m_addr = ((m_row + m_scroll) % ROWS) * 80 + m_col;
        end
        hs = (m_h >= H_VIS + H_FP && m_h < H_VIS + H_FP + H_SYNC)
             ? SYNC_POL : ~SYNC_POL;
        vs = (m_v >= V_VIS + V_FP && m_v < V_VIS + V_FP + V_SYNC)
             ? SYNC_POL : ~SYNC_POL;
        ls = (m_h == 0) && (m_v < V_VIS);
        hit = vis && i_cursor_en && m_blink &&
              (m_row == int'(i_cursor_row)) && (m_col == int'(i_cursor_col));
        sbq.push_back({hs, vs, vis, fs, ls, 7'(m_col), 5'(m_row),
                       3'(m_px), 5'(m_py), 11'(m_addr), hit, m_blink});
        if (i_scroll_valid) m_scroll = int'(i_scroll) % ROWS;
    endtask

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) model_reset();
        else model_step();
    end

    always @(negedge i_clk) begin
        if (!i_rst_n) check("rst", dut_vec, RST_VEC);
        else if (sbq.size() > 0) check("pix", dut_vec, sbq.pop_front());
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (n < 2 * FRAME) begin
            step(1);
            n++;
            if (o_frame_start) break;
        end
        if (!o_frame_start) check("fs_wait", 38'(n), 38'(FRAME));
        nfs++;
    endtask

    task automatic max_col(input int n, output int mx);
        mx = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (o_visible && int'(o_cell_col) > mx) mx = int'(o_cell_col);
        end
    endtask

    task automatic find_cell(input int r, input int c, output int addr);
        addr = -1;
        for (int i = 0; i < FRAME; i++) begin
            step(1);
            if (o_visible && int'(o_cell_row) == r && int'(o_cell_col) == c) begin
                addr = int'(o_vram_addr);
                break;
            end
        end
    endtask

    task automatic run_frame(output int len, output int hits);
        len = 0;
        hits = 0;
        while (len < 2 * FRAME) begin
            step(1);
            len++;
            if (o_cursor_hit) hits++;
            if (o_frame_start) break;
        end
        nfs++;
    endtask

    initial begin
        int n, mx, hs_first, hs_low, ls_first, addr, len, hits;
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b1;

        wait_fs(n);
        check("fs_lat", 38'(n), 38'((V_TOT - V_VIS) * H_TOT));

        hs_first = -1; hs_low = 0; ls_first = -1;
        for (int i = 1; i <= 2 * H_TOT; i++) begin
            step(1);
            if (!o_hsync && hs_first < 0) hs_first = i;
            if (!o_hsync && i < H_TOT) hs_low++;
            if (o_line_start && ls_first < 0) ls_first = i;
        end
        check("hs_beg", 38'(hs_first), 38'(H_VIS + H_FP));
        check("hs_width", 38'(hs_low), 38'(H_SYNC));
        check("line_len", 38'(ls_first), 38'(H_TOT));

        i_repeat = 2'd1;
        wait_fs(n);
        mx = 0;
        for (int i = 1; i < H_TOT; i++) begin
            step(1);
            if (i == 28) check("r2_addr28", 38'(o_vram_addr), 38'(3));
            if (o_visible && int'(o_cell_col) > mx) mx = int'(o_cell_col);
        end
        check("r2_cmax", 38'(mx), 38'(3));

        i_repeat = 2'd2;
        max_col(2 * H_TOT, mx);
        check("mid_cmax", 38'(mx), 38'(3));

        wait_fs(n);
        max_col(H_TOT - 1, mx);
        check("r4_cmax", 38'(mx), 38'(1));

        i_scroll = 5'd3;
        i_scroll_valid = 1'b1;
        step(1);
        i_scroll_valid = 1'b0;
        i_repeat = 2'd0;
        wait_fs(n);
        find_cell(1, 2, addr);
        check("scroll3", 38'(addr), 38'(2));

        i_scroll = 5'd30;
        i_scroll_valid = 1'b1;
        step(1);
        i_scroll_valid = 1'b0;
        wait_fs(n);
        find_cell(1, 2, addr);
        check("scroll30", 38'(addr), 38'(242));

        wait_fs(n);
        for (int k = 0; k < 4; k++) begin
            int exp_hits;
            exp_hits = ((nfs % 4) == 2 || (nfs % 4) == 3) ? 8 : 0;
            run_frame(len, hits);
            check("frame_len", 38'(len), 38'(FRAME));
            check("cur_hits", 38'(hits), 38'(exp_hits));
        end

        step(5 * H_TOT + 10);
        #2 i_rst_n = 1'b0;
        #1 check("async_rst", dut_vec, RST_VEC);
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        nfs = 0;
        wait_fs(n);
        check("fs_lat2", 38'(n), 38'((V_TOT - V_VIS) * H_TOT));
        run_frame(len, hits);
        check("frame_len2", 38'(len), 38'(FRAME));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vdu_scan_gen.md
VDU_SCAN_GEN -- requirements
Module: vdu_scan_gen

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: H_VIS 640 visible pixels; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_VIS 480 visible lines; V_FP 10 v front porch; V_SYNC 2 v sync width; V_BP 29 v back porch; SYNC_POL 0 active sync level; CELL_W 8 cell width in source pixels; CELL_H 20 cell height in lines; ROWS 24 text rows; BLINK_FR 16 frames per blink half-period.
REQ-002 i_clk  in  1  pixel clock; the only clock.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_repeat  in  2  pixel repeat select (0:x1, 1:x2, 2:x4, 3:x1).
REQ-005 i_scroll_valid  in  1  qualifies i_scroll.
REQ-006 i_scroll  in  5  first displayed VRAM row.
REQ-007 i_cursor_en, i_cursor_row[4:0], i_cursor_col[6:0]  in  cursor enable and cell position.
REQ-008 o_hsync, o_vsync  out  1  sync, level SYNC_POL while asserted.
REQ-009 o_visible  out  1  current pixel is in the active area.
REQ-010 o_frame_start, o_line_start  out  1  single-cycle pulses.
REQ-011 o_cell_col[6:0], o_cell_row[4:0], o_px[2:0], o_py[4:0]  out  current cell and in-cell position.
REQ-012 o_vram_addr  out  11  character address of the current cell.
REQ-013 o_cursor_hit  out  1  current cell is the cursor cell and blink phase is on.
REQ-014 o_blink  out  1  blink phase.

Function
REQ-015 h_cnt SHALL run 0..H_TOT-1 (H_TOT = sum of H params); v_cnt SHALL increment on h_cnt wrap and run 0..V_TOT-1.
REQ-016 o_visible SHALL be (h_cnt<H_VIS)&&(v_cnt<V_VIS); sync SHALL assert for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], with the same rule for v.
REQ-017 o_line_start SHALL pulse when h_cnt==0 and v_cnt<V_VIS; o_frame_start SHALL pulse when h_cnt==0 and v_cnt==0.
REQ-018 Repeat factor R SHALL be latched from i_repeat only on the o_frame_start cycle; the frame in progress SHALL be unaffected by any mid-frame change.
REQ-019 Effective columns SHALL be C = H_VIS/(CELL_W*R) (80/40/20 at defaults).
REQ-020 While visible, a repeat counter SHALL count 0..R-1; o_px SHALL advance 0..CELL_W-1 on its wrap; o_cell_col SHALL advance on o_px wrap and clear after C-1.
REQ-021 o_py SHALL advance on each visible line end and wrap after CELL_H-1; o_cell_row SHALL advance on that wrap and wrap after ROWS-1; all four counters SHALL clear at frame start.
REQ-022 o_vram_addr SHALL be ((o_cell_row+scroll) mod ROWS)*80 + o_cell_col; stride 80 regardless of R; all arithmetic SHALL be at least 12 bits wide before truncation.
REQ-023 The scroll register SHALL update on i_scroll_valid at any time, with values >=ROWS reduced mod ROWS, and SHALL take effect from the next visible cell.
REQ-024 frame_cnt SHALL count frames; o_blink SHALL toggle and frame_cnt clear when frame_cnt reaches BLINK_FR-1 at frame start.
REQ-025 o_cursor_hit SHALL be i_cursor_en && o_blink && cell match; it SHALL be 0 when not visible.
REQ-026 All outputs SHALL be registered and mutually cycle-aligned; o_visible, sync and cell outputs SHALL describe the same pixel.
REQ-027 Outside the visible area, cell/px/py outputs SHALL hold their values and o_vram_addr SHALL hold.

Reset
REQ-028 On reset: h_cnt=0, v_cnt=V_VIS (blanking), R=1, scroll=0, frame_cnt=0, o_blink=0, all cell counters 0.
REQ-029 During reset: sync outputs inactive (~SYNC_POL), all pulses and o_visible/o_cursor_hit 0, o_vram_addr 0.
REQ-030 Reset deassertion SHALL be taken synchronously; reset mid-frame SHALL abandon the frame, and the first o_frame_start SHALL occur (V_TOT-V_VIS)*H_TOT cycles after release.

Verification
REQ-031 Free-run at defaults -> H_TOT=800 and V_TOT=521 between pulses; hsync low for 96 cycles starting at h=656; first o_frame_start 32,800 cycles after reset.
REQ-032 i_repeat=1 -> o_px steps every 2 cycles, o_cell_col 0..39, o_vram_addr at line 0 pixel 632 = 39.
REQ-033 i_scroll=23, row 1 cell col 5 -> o_vram_addr = 0*80+5 = 5; i_scroll=30 -> treated as 6.
REQ-034 i_repeat changed mid-frame -> no change until the next o_frame_start, then the new column count.
REQ-035 Cursor at (2,3) enabled -> o_cursor_hit high only on cell (2,3) pixels, in 16-frame on/off phases.
REQ-036 Assert i_rst_n low at v=100 -> all outputs reach reset values immediately (async); release -> timing per REQ-030.
